multi_clkdiv: RTL and testbench

Parametrised multi-channel clock-enable generator: the next generation of the design's fixed clock divider. Each of NCH channels divides the master clock by a runtime-programmable ratio. Each channel produces a one-cycle `tick` enable strobe and an optional 50 %-duty square wave `sqw`. It sits beside the VGA/seven-segment/game logic and replaces hard-wired counter bits and fixed game-rate counters with enables that all run in the single `clk` domain.

---
 rtl/multi_clkdiv.sv | 103 ++++++++++
 tb/tb_multi_clkdiv.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/multi_clkdiv.sv
// multi_clkdiv: NCH independent clock-enable dividers with staged divisor writes, global run/sync.
// Optional square-wave outputs are built only when MULTI_CLKDIV_SQW_EN is defined.
module multi_clkdiv #(
    parameter int NCH     = 4,
    parameter int CW      = 27,
    parameter int DEF_DIV = 25000000,
    localparam int WCW    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           en,
    input  logic           sync,
    input  logic           wr,
    input  logic [WCW-1:0] wr_ch,
    input  logic [CW-1:0]  wr_div,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] sqw,
    output logic [NCH-1:0] pend
);

    logic [CW-1:0]  r_div  [NCH];
    logic [CW-1:0]  r_cnt  [NCH];
    logic [CW-1:0]  r_pdiv [NCH];
    logic [NCH-1:0] r_pend;
    logic [NCH-1:0] r_tick;
    logic [NCH-1:0] w_wrap;

    // A channel wraps when it is running with a non-zero divisor and its count reaches div-1.
    always_comb begin
        w_wrap = '0;
        for (int i = 0; i < NCH; i++) begin
            w_wrap[i] = en && !sync && (r_div[i] != '0) && (r_cnt[i] == r_div[i] - CW'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < NCH; i++) begin
                r_div[i]  <= CW'(DEF_DIV);
                r_cnt[i]  <= '0;
                r_pdiv[i] <= '0;
            end
            r_pend <= '0;
            r_tick <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (sync) begin
                    r_cnt[i]  <= '0;
                    r_tick[i] <= 1'b0;
                    if (r_pend[i]) begin
                        r_div[i]  <= r_pdiv[i];
                        r_pend[i] <= 1'b0;
                    end
                end else if (!en) begin
                    r_tick[i] <= 1'b0;
                end else if (r_div[i] == '0) begin
                    r_cnt[i]  <= '0;
                    r_tick[i] <= 1'b0;
                    if (r_pend[i]) begin
                        r_div[i]  <= r_pdiv[i];
                        r_pend[i] <= 1'b0;
                    end
                end else if (w_wrap[i]) begin
                    r_cnt[i]  <= '0;
                    r_tick[i] <= 1'b1;
                    if (r_pend[i]) begin
                        r_div[i]  <= r_pdiv[i];
                        r_pend[i] <= 1'b0;
                    end
                end else begin
                    r_cnt[i]  <= r_cnt[i] + CW'(1);
                    r_tick[i] <= 1'b0;
                end
                // NOTE: this write comes last so a same-cycle write overrides the pend clear
                // from a wrap or sync above; the old pdiv is applied, the new one stays staged.
                if (wr && (wr_ch == WCW'(i))) begin
                    r_pdiv[i] <= wr_div;
                    r_pend[i] <= 1'b1;
                end
            end
        end
    end

`ifdef MULTI_CLKDIV_SQW_EN
    logic [NCH-1:0] r_sqw;

    always_ff @(posedge clk) begin
        if (clr || sync) begin
            r_sqw <= '0;
        end else begin
            r_sqw <= r_sqw ^ w_wrap;
        end
    end

    assign sqw = r_sqw;
`else
    assign sqw = '0;
`endif

    assign tick = r_tick;
    assign pend = r_pend;

endmodule

// File: tb/tb_multi_clkdiv.sv
// Scoreboard bench for multi_clkdiv: random and directed stimulus against a countdown reference model.
// A 3-channel copy shares the inputs so that wr_ch=3 exercises the out-of-range write path.
module tb_multi_clkdiv;

    localparam int NCH = 4;
    localparam int CW  = 8;
    localparam int DD  = 4;

    typedef struct packed {
        logic [NCH-1:0] tick;
        logic [NCH-1:0] sqw;
        logic [NCH-1:0] pend;
    } exp_t;

    logic          clk = 1'b0;
    logic          clr, en, sync, wr;
    logic [1:0]    wr_ch;
    logic [CW-1:0] wr_div;
    logic [3:0]    tick, sqw, pend;
    logic [2:0]    tick3, sqw3, pend3;

    int n_checks = 0;
    int n_errors = 0;
    exp_t sb [$];

    // Reference model: remaining edges until the next tick, and ticks since alignment for sqw.
    int m_div  [NCH];
    int m_rem  [NCH];
    int m_pdiv [NCH];
    bit m_pend [NCH];
    bit m_tick [NCH];
    int m_ntk  [NCH];

    multi_clkdiv #(.NCH(4), .CW(CW), .DEF_DIV(DD)) u_dut (
        .clk(clk), .clr(clr), .en(en), .sync(sync), .wr(wr), .wr_ch(wr_ch),
        .wr_div(wr_div), .tick(tick), .sqw(sqw), .pend(pend)
    );

    multi_clkdiv #(.NCH(3), .CW(CW), .DEF_DIV(DD)) u_dut3 (
        .clk(clk), .clr(clr), .en(en), .sync(sync), .wr(wr), .wr_ch(wr_ch),
        .wr_div(wr_div), .tick(tick3), .sqw(sqw3), .pend(pend3)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
        end
    endtask

    function automatic void model_step();
        for (int i = 0; i < NCH; i++) begin
            if (clr) begin
                m_div[i] = DD; m_rem[i] = DD; m_pdiv[i] = 0;
                m_pend[i] = 0; m_tick[i] = 0; m_ntk[i] = 0;
            end else begin
                m_tick[i] = 0;
                if (sync) begin
                    if (m_pend[i]) begin m_div[i] = m_pdiv[i]; m_pend[i] = 0; end
                    m_rem[i] = m_div[i];
                    m_ntk[i] = 0;
                end else if (en) begin
                    if (m_div[i] == 0) begin
                        if (m_pend[i]) begin
                            m_div[i] = m_pdiv[i]; m_pend[i] = 0; m_rem[i] = m_div[i];
                        end
                    end else begin
                        m_rem[i]--;
                        if (m_rem[i] == 0) begin
                            m_tick[i] = 1;
                            m_ntk[i]++;
                            if (m_pend[i]) begin m_div[i] = m_pdiv[i]; m_pend[i] = 0; end
                            m_rem[i] = m_div[i];
                        end
                    end
                end
                if (wr && int'(wr_ch) == i) begin
                    m_pdiv[i] = int'(wr_div);
                    m_pend[i] = 1;
                end
            end
        end
    endfunction

    // Drive one cycle of inputs, advance the model to the next edge and queue its outputs.
    task automatic cyc(input bit c, input bit e, input bit s, input bit w,
                       input logic [1:0] ch, input logic [CW-1:0] d);
        exp_t x;
        clr = c; en = e; sync = s; wr = w; wr_ch = ch; wr_div = d;
        model_step();
        for (int i = 0; i < NCH; i++) begin
            x.tick[i] = m_tick[i];
            x.pend[i] = m_pend[i];
`ifdef MULTI_CLKDIV_SQW_EN
            x.sqw[i] = m_ntk[i][0];
`else
            x.sqw[i] = 1'b0;
`endif
        end
        sb.push_back(x);
        @(negedge clk);
    endtask

    task automatic run(input bit e, input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, e, 1'b0, 1'b0, 2'd0, '0);
    endtask

    task automatic wr_div_to(input logic [1:0] ch, input logic [CW-1:0] d);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, ch, d);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                check("tick",  tick, x.tick);
                check("sqw",   sqw,  x.sqw);
                check("pend",  pend, x.pend);
                check("tick3", {1'b0, tick3}, {1'b0, x.tick[2:0]});
                check("sqw3",  {1'b0, sqw3},  {1'b0, x.sqw[2:0]});
                check("pend3", {1'b0, pend3}, {1'b0, x.pend[2:0]});
            end
        end
    end

    initial begin : stimulus
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, '0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, '0);
        run(1'b1, 20);
        // ch1 slows to 6 at the next wrap
        run(1'b1, 1);
        wr_div_to(2'd1, 8'd6);
        run(1'b1, 20);
        // ch2 disabled, then re-enabled with div 3
        wr_div_to(2'd2, 8'd0);
        run(1'b1, 12);
        wr_div_to(2'd2, 8'd3);
        run(1'b1, 10);
        // ch0 at div 1; wr_ch 3 is out of range for the 3-channel copy
        wr_div_to(2'd0, 8'd1);
        run(1'b1, 10);
        wr_div_to(2'd3, 8'd7);
        run(1'b1, 5);
        // sync with ch3 pending, then sync coinciding with a write
        wr_div_to(2'd3, 8'd5);
        run(1'b1, 2);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, '0);
        run(1'b1, 15);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 8'd2);
        run(1'b1, 12);
        // freeze with a write accepted, then clr while writes are pending
        run(1'b1, 3);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 8'd5);
        run(1'b0, 9);
        wr_div_to(2'd0, 8'd2);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 8'd3);
        run(1'b1, 12);
        // random traffic with short divisors so many wraps occur
        for (int k = 0; k < 3000; k++) begin
            cyc(($urandom_range(0, 499) == 0),
                ($urandom_range(0, 9) != 0),
                ($urandom_range(0, 59) == 0),
                ($urandom_range(0, 9) == 0),
                2'($urandom_range(0, 3)),
                CW'($urandom_range(0, 9)));
        end
        @(posedge clk);
        #2;
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
